msi_message_tx: RTL
===================

// Module: msi_message_tx
// PURPOSE
//  Requester side of MSI: turns per-vector interrupt pulses into MSI memory-write requests.
//  Composes the write from the programmed Message Address/Data and Multiple Message Enable (MME).
//  Sits between function interrupt sources and the TLP transmit path, fed by the MSI capability registers.
// PARAMETERS
//  NUM_VEC   32  vectors requested by the function; power of 2, 1..32
//  ADDR64    1   1 = 64-bit address capable; 0 = always 32-bit write
// PORTS
//  clk                    in   1        core clock; all logic on posedge
//  rst                    in   1        synchronous reset, active-high
//  msi_enable             in   1        MSI Enable from the capability
//  multiple_message_enable in  3        MME; allocated vectors = 2^MME
//  message_addr           in   64       Message Address (upper/lower)
//  message_data           in   16       Message Data register value
//  int_req                in   NUM_VEC  one-cycle request pulse per vector
//  mask_bits              in   NUM_VEC  per-vector mask (only with MSI_MASK_EN)
//  pending_bits           out  NUM_VEC  sticky pending per allocated vector
//  tx_valid               out  1        write request valid
//  tx_ready               in   1        transmit path accepts request
//  tx_addr                out  64       DW-aligned target address, [1:0]=0
//  tx_is64                out  1        1 = 4DW header (64-bit address)
//  tx_data                out  32       payload {16'h0, composed data}
// BEHAVIOUR
//  - Reset: pending_bits=0, tx_valid=0, tx_addr=0, tx_is64=0, tx_data=0, FSM=IDLE.
//  - Effective MME: min(MME, 5, log2(NUM_VEC)); alloc = 2^eff, mask m = alloc-1.
//  - Folding: int_req[v] sets pending[v & m]; bits >= alloc never set.
//  - Pending set wins over same-cycle clear for the same bit.
//  - msi_enable=0: int_req ignored; pending_bits cleared, except in SEND (complete first).
//  - FSM IDLE: if msi_enable and any eligible pending -> latch lowest-index eligible vector k,
//    register tx_addr/tx_data/tx_is64, go SEND; tx_valid rises next cycle.
//  - FSM SEND: tx_valid=1, outputs stable until tx_valid&&tx_ready; on handshake clear
//    pending[k] (unless re-set same cycle), go IDLE; tx_valid low for >=1 cycle.
//  - Latency: int_req at cycle n -> pending at n+1 -> tx_valid at n+2 (if idle, ready).
//  - Data: tx_data[15:0] = (message_data & ~m) | (k & m); tx_data[31:16]=0.
//  - Addr: tx_addr={message_addr[63:2],2'b00}; tx_is64 = ADDR64 && message_addr[63:32]!=0;
//    if tx_is64=0, tx_addr[63:32]=0.
//  - MME/data/addr changes during SEND do not affect the in-flight request.
//  - rst mid-SEND: request dropped, all state to reset values next cycle.
// CONFIGURATION
//  MSI_MASK_EN defined: mask_bits port present; masked vectors stay/become pending
//    but are not eligible; unmask with pending set -> sent from next IDLE evaluation.
//  MSI_MASK_EN undefined: no mask_bits port; every pending allocated vector eligible.
// TESTING
//  1. MME=0, data=16'h4A30, addr=0xFEE0_0000, int_req[0] pulse, ready=1 ->
//     one write tx_data=0x00004A30, tx_is64=0, pending[0] clears.
//  2. MME=3, data=16'h4A3F, int_req[5] -> tx_data=0x00004A3D;
//     int_req[13] -> folds to vector 5, same data.
//  3. int_req[2],[7] same cycle, MME=3 -> vector 2 then 7; tx_valid low one cycle between.
//  4. addr=0x1_0000_0004, ADDR64=1 -> tx_is64=1, tx_addr=0x1_0000_0004;
//     ready held low 10 cycles -> outputs stable.
//  5. msi_enable dropped mid-SEND -> current write completes, pending_bits=0 after.
//  6. MSI_MASK_EN: mask[1]=1, int_req[1] -> pending[1]=1, no tx;
//     unmask -> tx_valid within 2 cycles.

Source files
------------

// File: rtl/msi_message_tx.sv
// MSI requester: folds per-vector interrupt pulses into pending bits and issues one
// MSI memory write at a time. Optional per-vector masking is compiled in with MSI_MASK_EN.
module msi_message_tx #(
    parameter int NUM_VEC = 32,
    parameter bit ADDR64  = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               msi_enable,
    input  logic [2:0]         multiple_message_enable,
    input  logic [63:0]        message_addr,
    input  logic [15:0]        message_data,
    input  logic [NUM_VEC-1:0] int_req,
`ifdef MSI_MASK_EN
    input  logic [NUM_VEC-1:0] mask_bits,
`endif
    output logic [NUM_VEC-1:0] pending_bits,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic [63:0]        tx_addr,
    output logic               tx_is64,
    output logic [31:0]        tx_data
);

    localparam int LOG2_VEC = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 0;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_VEC-1:0] pending_q, pending_d;
    logic [4:0]         vec_q, vec_d;
    logic               tx_valid_q, tx_valid_d;
    logic [63:0]        tx_addr_q, tx_addr_d;
    logic               tx_is64_q, tx_is64_d;
    logic [31:0]        tx_data_q, tx_data_d;

    logic [2:0]         eff_mme;
    logic [4:0]         vec_mask;
    logic [NUM_VEC-1:0] alloc_bits;
    logic [NUM_VEC-1:0] fold_set;
    logic [NUM_VEC-1:0] eligible;
    logic [4:0]         sel_idx;
    logic               sel_found;
    logic               handshake;
    logic               addr_is64;

    // Granted vector count is limited by what the function requested and the 32-vector cap.
    always_comb begin
        eff_mme = multiple_message_enable;
        if (eff_mme > 3'd5) begin
            eff_mme = 3'd5;
        end
        if (eff_mme > 3'(LOG2_VEC)) begin
            eff_mme = 3'(LOG2_VEC);
        end
    end

    assign vec_mask = ~(5'h1f << eff_mme);

    generate
        for (genvar gi = 0; gi < NUM_VEC; gi++) begin : g_alloc
            assign alloc_bits[gi] = ((5'(gi) & ~vec_mask) == 5'd0);
        end
    endgenerate

    // A request on any vector lands on its low bits within the allocated range.
    always_comb begin
        fold_set = '0;
        for (int v = 0; v < NUM_VEC; v++) begin
            if (int_req[v]) begin
                fold_set[5'(v) & vec_mask] = 1'b1;
            end
        end
    end

`ifdef MSI_MASK_EN
    assign eligible = pending_q & alloc_bits & ~mask_bits;
`else
    assign eligible = pending_q & alloc_bits;
`endif

    always_comb begin
        sel_idx = 5'd0;
        for (int v = NUM_VEC - 1; v >= 0; v--) begin
            if (eligible[v]) begin
                sel_idx = 5'(v);
            end
        end
    end

    assign sel_found = |eligible;
    assign handshake = tx_valid_q && tx_ready;
    assign addr_is64 = ADDR64 && (|message_addr[63:32]);

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        vec_d      = vec_q;
        tx_valid_d = tx_valid_q;
        tx_addr_d  = tx_addr_q;
        tx_is64_d  = tx_is64_q;
        tx_data_d  = tx_data_q;

        case (state_q)
            ST_IDLE: begin
                if (msi_enable && sel_found) begin
                    state_d    = ST_SEND;
                    tx_valid_d = 1'b1;
                    vec_d      = sel_idx;
                    tx_is64_d  = addr_is64;
                    tx_addr_d  = {(addr_is64 ? message_addr[63:32] : 32'h0),
                                  message_addr[31:2], 2'b00};
                    tx_data_d  = {16'h0, (message_data & ~{11'h0, vec_mask}) |
                                         {11'h0, sel_idx & vec_mask}};
                end
            end
            ST_SEND: begin
                if (handshake) begin
                    state_d           = ST_IDLE;
                    tx_valid_d        = 1'b0;
                    pending_d[vec_q]  = 1'b0;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                tx_valid_d = 1'b0;
            end
        endcase

        // New requests are ORed after the handshake clear so a same-cycle set survives.
        if (msi_enable) begin
            pending_d = pending_d | fold_set;
        end else if ((state_q != ST_SEND) || handshake) begin
            pending_d = '0;
        end
        pending_d = pending_d & alloc_bits;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            vec_q      <= 5'd0;
            tx_valid_q <= 1'b0;
            tx_addr_q  <= 64'h0;
            tx_is64_q  <= 1'b0;
            tx_data_q  <= 32'h0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            vec_q      <= vec_d;
            tx_valid_q <= tx_valid_d;
            tx_addr_q  <= tx_addr_d;
            tx_is64_q  <= tx_is64_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign pending_bits = pending_q;
    assign tx_valid     = tx_valid_q;
    assign tx_addr      = tx_addr_q;
    assign tx_is64      = tx_is64_q;
    assign tx_data      = tx_data_q;

endmodule
